xadc_drp_arbiter: RTL and testbench
===================================

Name: xadc_drp_arbiter

Overview:
- Shares the single XADC DRP port among NUM_REQ independent requesters, for example the status-monitor FSM, the alarm-threshold configuration writer and the host register bridge.
- Serialises their read/write transactions with round-robin arbitration and drives the DRP strobe and address/data lines.
- Returns read data or a timeout error to the owning requester.
- Sits between the requester FSMs and the XADC primitive's DRP pins.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT, 255, cycles to wait for drdy after den before aborting (1..65535).
- ADDR_W, 7, DRP address width.
- DATA_W, 16, DRP data width.

Ports:
- I_sys_clk  in  1  DRP/system clock.
- I_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held high until that requester's ack.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_di  in  NUM_REQ*DATA_W  packed write data.
- req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- req_err  out  NUM_REQ  qualifies req_ack: 1 = timeout.
- rsp_data  out  DATA_W  read data; valid in the req_ack cycle.
- owner  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- arb_busy  out  1  high from grant through ack.
- drp_daddr  out  ADDR_W  to XADC DADDR.
- drp_den  out  1  to XADC DEN.
- drp_dwe  out  1  to XADC DWE.
- drp_di  out  DATA_W  to XADC DI.
- drp_do  in  DATA_W  from XADC DO.
- drp_drdy  in  1  from XADC DRDY.

Behaviour:
- Clock/reset: one clock, I_sys_clk. I_rst_n is asynchronous, active-low; deassertion is synchronised externally.
- Reset values: all outputs 0, rr pointer 0, state IDLE, timeout counter 0.
- Timing: all outputs are registered.
- IDLE:
  - If any req_valid, grant the first requester at or after the rr pointer (wrapping).
  - Latch that requester's we/addr/di into drp_dwe/drp_daddr/drp_di, set owner, arb_busy=1, go to ISSUE.
- ISSUE (one cycle):
  - drp_den=1; drp_dwe equals the latched we, so DWE is high only together with DEN.
  - Clear the timeout counter, go to WAIT.
- WAIT:
  - drp_den=0, drp_dwe=0.
  - On drp_drdy: capture drp_do into rsp_data (reads and writes alike), go to DONE with err=0.
  - Else increment the counter. When the counter equals TIMEOUT, go to DONE with err=1 and rsp_data=0.
- DONE (one cycle):
  - req_ack[owner]=1 and req_err[owner]=err.
  - Advance the rr pointer to owner+1, wrapping at NUM_REQ.
  - arb_busy=0 next cycle; go to IDLE.
- Minimum transaction latency: grant at cycle 0 → den at cycle 1 → drdy at earliest cycle 2 → ack at cycle 3.
- Back-to-back operation: the next grant occurs in the cycle after DONE. A requester holding req_valid after its ack is treated as a new request.
- drp_daddr/drp_di remain stable from ISSUE through DONE.
- Boundary cases:
  - Simultaneous requests: resolved strictly by rr priority. No requester waits more than NUM_REQ-1 transactions.
  - req_valid dropped after grant: the transaction completes and ack still pulses. A requester's inputs are sampled only at grant.
  - drp_drdy outside WAIT: ignored, no state change.
  - drdy in the same cycle the counter hits TIMEOUT: drdy wins, err=0.
  - Reset mid-transaction: immediate return to IDLE, den/dwe=0, no ack. The XADC may still return drdy, which is ignored per the rule above.
  - NUM_REQ=1: the arbiter degenerates to pass-through sequencing with the pointer fixed at 0.

Decomposition:
- Shared package xadc_pkg:
  - State encoding (IDLE, ISSUE, WAIT, DONE).
  - DRP address constants: 0x00 TEMP, 0x01 VCCINT, 0x02 VCCAUX, 0x06 VCCBRAM, 0x20–0x27 MAX/MIN, 0x40–0x42 CFG0–2, 0x48–0x4F SEQ, 0x50–0x58 alarm thresholds.
  - DATA_W/ADDR_W defaults.
- Sub-module rr_arbiter:
  - Combinational one-hot grant from req vector and pointer, plus the pointer register updated on an advance strobe.
  - Reused elsewhere for other shared resources.

Test Plan:
- Single read: only req 1 reads addr 0x00; the model returns drdy 2 cycles after den with DO=16'h9A3C → den one cycle with daddr=0x00 and dwe=0; req_ack[1] 1 cycle after drdy; rsp_data=16'h9A3C; err=0.
- Write: req 0 writes 16'h03FF to 0x40 → den and dwe high in the same single cycle; di=16'h03FF; ack[0] after drdy.
- Contention: reqs 0, 1 and 2 asserted simultaneously and held, pointer 0 → grant order 0, 1, 2, 0, ...; one ack per transaction; arb_busy never high for two owners at once.
- Timeout: TIMEOUT=8, model never drives drdy → ack with err=1 exactly 9 cycles after den; rsp_data=0; the next pending requester is granted next.
- Reset in WAIT: assert I_rst_n=0 mid-wait, then a late drdy arrives after reset release → outputs cleared asynchronously; no ack; late drdy ignored; the next request proceeds normally.
- drdy coinciding with timeout: drdy asserted on the cycle the counter equals TIMEOUT → err=0 and data captured.

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared XADC DRP definitions: FSM states, register map and bus widths.
// Imported by the DRP arbiter and by requester FSMs that target the XADC.
package xadc_pkg;

  localparam int XADC_ADDR_W = 7;
  localparam int XADC_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } drp_state_e;

  localparam logic [6:0] DRP_TEMP      = 7'h00;
  localparam logic [6:0] DRP_VCCINT    = 7'h01;
  localparam logic [6:0] DRP_VCCAUX    = 7'h02;
  localparam logic [6:0] DRP_VCCBRAM   = 7'h06;
  localparam logic [6:0] DRP_MAXMIN_LO = 7'h20;
  localparam logic [6:0] DRP_MAXMIN_HI = 7'h27;
  localparam logic [6:0] DRP_CFG0      = 7'h40;
  localparam logic [6:0] DRP_CFG1      = 7'h41;
  localparam logic [6:0] DRP_CFG2      = 7'h42;
  localparam logic [6:0] DRP_SEQ_LO    = 7'h48;
  localparam logic [6:0] DRP_SEQ_HI    = 7'h4F;
  localparam logic [6:0] DRP_ALM_LO    = 7'h50;
  localparam logic [6:0] DRP_ALM_HI    = 7'h58;

  function automatic logic is_alarm_addr(input logic [6:0] a);
    return (a >= DRP_ALM_LO) && (a <= DRP_ALM_HI);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester at or after the pointer, wrapping.
// The pointer moves to one past the last served index on i_adv.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gidx
);

  logic [IW-1:0] r_ptr;

  always_comb begin
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_j;
    logic          w_found;
    o_gnt   = '0;
    o_gidx  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_j     = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N))
        w_sum = w_sum - (IW+1)'(N);
      w_j = w_sum[IW-1:0];
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_gidx     = w_j;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_ptr <= '0;
    else if (i_adv)
      r_ptr <= (i_last == IW'(N-1)) ? '0 : i_last + IW'(1);
  end

endmodule

// File: rtl/xadc_drp_arbiter.sv
// Shares one XADC DRP port among NUM_REQ requesters with round-robin
// arbitration, a one-cycle DEN strobe and a drdy timeout.
module xadc_drp_arbiter
  import xadc_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = XADC_ADDR_W,
  parameter int DATA_W  = XADC_DATA_W,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      I_sys_clk,
  input  logic                      I_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_di,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [IW-1:0]             owner,
  output logic                      arb_busy,
  output logic [ADDR_W-1:0]         drp_daddr,
  output logic                      drp_den,
  output logic                      drp_dwe,
  output logic [DATA_W-1:0]         drp_di,
  input  logic [DATA_W-1:0]         drp_do,
  input  logic                      drp_drdy
);

  drp_state_e           r_state;
  logic [15:0]          r_cnt;
  logic [NUM_REQ-1:0]   r_gnt_oh;
  logic [IW-1:0]        r_owner;
  logic                 r_busy;
  logic [ADDR_W-1:0]    r_daddr;
  logic [DATA_W-1:0]    r_di;
  logic                 r_den;
  logic                 r_dwe;
  logic [NUM_REQ-1:0]   r_ack;
  logic [NUM_REQ-1:0]   r_err;
  logic [DATA_W-1:0]    r_rsp;

  logic [NUM_REQ-1:0]   w_gnt;
  logic [IW-1:0]        w_gidx;
  logic                 w_adv;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_di;
  logic                 w_we;
  logic [16:0]          w_cnt_nxt;
  logic                 w_tmo;

  assign w_adv     = (r_state == ST_DONE);
  assign w_cnt_nxt = {1'b0, r_cnt} + 17'd1;
  assign w_tmo     = (w_cnt_nxt == 17'(TIMEOUT));

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .i_clk   (I_sys_clk),
    .i_rst_n (I_rst_n),
    .i_req   (req_valid),
    .i_adv   (w_adv),
    .i_last  (r_owner),
    .o_gnt   (w_gnt),
    .o_gidx  (w_gidx)
  );

  always_comb begin
    w_addr = '0;
    w_di   = '0;
    w_we   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_di   = req_di[i*DATA_W +: DATA_W];
        w_we   = req_we[i];
      end
    end
  end

  // drdy is only looked at in WAIT, so stray or late strobes are dropped.
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_gnt_oh <= '0;
      r_owner  <= '0;
      r_busy   <= 1'b0;
      r_daddr  <= '0;
      r_di     <= '0;
      r_den    <= 1'b0;
      r_dwe    <= 1'b0;
      r_ack    <= '0;
      r_err    <= '0;
      r_rsp    <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_gnt_oh <= w_gnt;
            r_owner  <= w_gidx;
            r_daddr  <= w_addr;
            r_di     <= w_di;
            r_dwe    <= w_we;
            r_den    <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_den   <= 1'b0;
          r_dwe   <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (drp_drdy) begin
            r_rsp   <= drp_do;
            r_ack   <= r_gnt_oh;
            r_state <= ST_DONE;
          end else if (w_tmo) begin
            r_rsp   <= '0;
            r_ack   <= r_gnt_oh;
            r_err   <= r_gnt_oh;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= w_cnt_nxt[15:0];
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ack   = r_ack;
  assign req_err   = r_err;
  assign rsp_data  = r_rsp;
  assign owner     = r_owner;
  assign arb_busy  = r_busy;
  assign drp_daddr = r_daddr;
  assign drp_den   = r_den;
  assign drp_dwe   = r_dwe;
  assign drp_di    = r_di;

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Bench for xadc_drp_arbiter: transaction-timeline model checked each
// cycle, plus directed scenarios with literal latency/data expectations.
module tb_xadc_drp_arbiter;

  localparam int N  = 3;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int TO = 8;

  logic I_sys_clk = 1'b0;
  logic I_rst_n   = 1'b0;
  always #5 I_sys_clk = ~I_sys_clk;

  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_di;
  logic [N-1:0]    req_ack, req_err;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      owner;
  logic            arb_busy;
  logic [AW-1:0]   drp_daddr;
  logic            drp_den, drp_dwe;
  logic [DW-1:0]   drp_di, drp_do;
  logic            drp_drdy;

  xadc_drp_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .I_sys_clk (I_sys_clk),
    .I_rst_n   (I_rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_di    (req_di),
    .req_ack   (req_ack),
    .req_err   (req_err),
    .rsp_data  (rsp_data),
    .owner     (owner),
    .arb_busy  (arb_busy),
    .drp_daddr (drp_daddr),
    .drp_den   (drp_den),
    .drp_dwe   (drp_dwe),
    .drp_di    (drp_di),
    .drp_do    (drp_do),
    .drp_drdy  (drp_drdy)
  );

  typedef struct {
    int            own;
    bit            err;
    logic [DW-1:0] data;
    int            lat;
  } rec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int            rq_cnt [N];
  int            dly    [N];
  int            cd     = 0;
  bit            late   = 0;
  logic [DW-1:0] do_val = '0;

  int            den_cyc  = 0;
  bit            den_flag = 0;
  logic          den_dwe  = 0;
  logic [DW-1:0] den_di   = '0;
  logic [AW-1:0] den_addr = '0;
  int            ack_total = 0;
  rec_t          alog[$];

  // Model: timeline of the active transaction, t=1 is the DEN cycle.
  bit            m_active = 0;
  int            m_ptr = 0, m_owner = 0, m_t = 0, m_ack_t = 0, mj = 0;
  bit            m_err = 0, m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_di = '0, m_data = '0;

  always @(posedge I_sys_clk) cyc <= cyc + 1;

  always @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      m_active = 0; m_ptr = 0; m_owner = 0; m_t = 0; m_ack_t = 0;
      m_err = 0; m_we = 0; m_addr = '0; m_di = '0; m_data = '0;
    end else if (m_active) begin
      if (m_ack_t != 0 && m_t == m_ack_t) begin
        m_active = 0;
        m_ptr = (m_owner + 1) % N;
      end else begin
        if (m_ack_t == 0 && m_t >= 2) begin
          if (drp_drdy === 1'b1) begin
            m_ack_t = m_t + 1; m_err = 0; m_data = drp_do;
          end else if (m_t - 1 == TO) begin
            m_ack_t = m_t + 1; m_err = 1; m_data = '0;
          end
        end
        m_t++;
      end
    end else if (req_valid != '0) begin
      for (int k = 0; k < N; k++) begin
        mj = (m_ptr + k) % N;
        if (!m_active && req_valid[mj]) begin
          m_active = 1;
          m_owner  = mj;
          m_we     = req_we[mj];
          m_addr   = req_addr[mj*AW +: AW];
          m_di     = req_di[mj*DW +: DW];
        end
      end
      m_t = 1; m_ack_t = 0;
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic bit pending();
    bit p = 0;
    for (int i = 0; i < N; i++) if (rq_cnt[i] > 0) p = 1;
    return p;
  endfunction

  task automatic set_req(input int i, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_di[i*DW +: DW] = d;
  endtask

  task automatic step();
    logic [N-1:0] eack;
    rec_t r;
    @(negedge I_sys_clk);
    if (I_rst_n) begin
      eack = '0;
      if (m_active && m_t == m_ack_t) eack[m_owner] = 1'b1;
      chk("busy", arb_busy, m_active);
      chk("den", drp_den, m_active && m_t == 1);
      chk("dwe", drp_dwe, m_active && m_t == 1 && m_we);
      chk("ack", req_ack, eack);
      chk("err", req_err, m_err ? eack : '0);
      chk("owner", owner, m_owner);
      if (m_active) begin
        chk("daddr", drp_daddr, m_addr);
        chk("di", drp_di, m_di);
      end
      if (eack != '0) chk("rsp", rsp_data, m_data);
    end
    if (drp_den) begin
      den_cyc = cyc; den_flag = 1;
      den_dwe = drp_dwe; den_di = drp_di; den_addr = drp_daddr;
    end
    if (req_ack != '0) begin
      r.own = 0;
      for (int i = 0; i < N; i++) if (req_ack[i]) r.own = i;
      r.err  = |req_err;
      r.data = rsp_data;
      r.lat  = cyc - den_cyc;
      alog.push_back(r);
      ack_total++;
    end
    for (int i = 0; i < N; i++) begin
      if (req_ack[i] && rq_cnt[i] > 0) rq_cnt[i]--;
      req_valid[i] = (rq_cnt[i] > 0);
    end
    drp_drdy = 1'b0;
    if (late) begin drp_drdy = 1'b1; late = 0; end
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin drp_drdy = 1'b1; drp_do = do_val; end
    end
    if (drp_den && dly[owner] > 0) cd = dly[owner];
  endtask

  task automatic run(input int maxc, input string nm);
    int n = 0;
    do begin step(); n++; end while ((pending() || arb_busy) && n < maxc);
    chk(nm, (pending() || arb_busy) ? 1 : 0, 0);
  endtask

  initial begin
    int base;
    int n;
    int exp_ord [6];
    exp_ord = '{0, 1, 2, 0, 1, 2};
    req_valid = '0; req_we = '0; req_addr = '0; req_di = '0;
    drp_do = '0; drp_drdy = 1'b0;
    for (int i = 0; i < N; i++) begin rq_cnt[i] = 0; dly[i] = 1; end
    repeat (3) @(negedge I_sys_clk);
    chk("rst_busy", arb_busy, 0);
    chk("rst_den", drp_den, 0);
    chk("rst_dwe", drp_dwe, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_err", req_err, 0);
    chk("rst_owner", owner, 0);
    chk("rst_rsp", rsp_data, 0);
    chk("rst_daddr", drp_daddr, 0);
    chk("rst_di", drp_di, 0);
    I_rst_n = 1'b1;

    set_req(1, 1'b0, 7'h00, 16'h0000);
    dly[1] = 2; do_val = 16'h9A3C; rq_cnt[1] = 1; alog.delete();
    run(60, "rd_done");
    chk("rd_count", alog.size(), 1);
    chk("rd_lat", alog[0].lat, 3);
    chk("rd_data", alog[0].data, 16'h9A3C);
    chk("rd_err", alog[0].err, 0);
    chk("rd_owner", alog[0].own, 1);
    chk("rd_dwe", den_dwe, 0);
    chk("rd_addr", den_addr, 7'h00);

    set_req(0, 1'b1, 7'h40, 16'h03FF);
    dly[0] = 1; do_val = 16'h0000; rq_cnt[0] = 1; alog.delete();
    run(60, "wr_done");
    chk("wr_count", alog.size(), 1);
    chk("wr_lat", alog[0].lat, 2);
    chk("wr_dwe", den_dwe, 1);
    chk("wr_di", den_di, 16'h03FF);
    chk("wr_addr", den_addr, 7'h40);
    chk("wr_owner", alog[0].own, 0);

    @(negedge I_sys_clk); I_rst_n = 1'b0;
    @(negedge I_sys_clk); I_rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b0, 7'(7'h48 + i), 16'h0000);
      dly[i] = 1; rq_cnt[i] = 2;
    end
    do_val = 16'h0C0C; alog.delete();
    run(200, "ct_done");
    chk("ct_count", alog.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < alog.size())
        chk($sformatf("ct_order%0d", k), alog[k].own, exp_ord[k]);

    set_req(0, 1'b0, 7'h50, 16'h0000);
    set_req(1, 1'b0, 7'h01, 16'h0000);
    dly[0] = 0; dly[1] = 1; do_val = 16'h5555;
    rq_cnt[0] = 1; rq_cnt[1] = 1; alog.delete();
    run(100, "to_done");
    chk("to_count", alog.size(), 2);
    chk("to_owner", alog[0].own, 0);
    chk("to_lat", alog[0].lat, TO + 1);
    chk("to_err", alog[0].err, 1);
    chk("to_data", alog[0].data, 0);
    chk("to_next", alog[1].own, 1);
    chk("to_next_err", alog[1].err, 0);
    chk("to_next_data", alog[1].data, 16'h5555);

    set_req(2, 1'b0, 7'h02, 16'h0000);
    dly[2] = TO; do_val = 16'hBEEF; rq_cnt[2] = 1; alog.delete();
    run(100, "co_done");
    chk("co_count", alog.size(), 1);
    chk("co_owner", alog[0].own, 2);
    chk("co_lat", alog[0].lat, TO + 1);
    chk("co_err", alog[0].err, 0);
    chk("co_data", alog[0].data, 16'hBEEF);

    set_req(1, 1'b0, 7'h06, 16'h0000);
    dly[1] = 0; rq_cnt[1] = 1; den_flag = 0;
    n = 0;
    while (!den_flag && n < 20) begin step(); n++; end
    chk("rw_den_seen", den_flag, 1);
    repeat (3) step();
    @(posedge I_sys_clk); #2;
    I_rst_n = 1'b0;
    #1;
    chk("rw_busy", arb_busy, 0);
    chk("rw_den", drp_den, 0);
    chk("rw_dwe", drp_dwe, 0);
    chk("rw_ack", req_ack, 0);
    chk("rw_owner", owner, 0);
    for (int i = 0; i < N; i++) rq_cnt[i] = 0;
    req_valid = '0; cd = 0; drp_drdy = 1'b0;
    @(negedge I_sys_clk);
    I_rst_n = 1'b1; late = 1; base = ack_total;
    repeat (6) step();
    chk("rw_noack", ack_total - base, 0);
    chk("rw_idle", arb_busy, 0);
    dly[1] = 1; do_val = 16'h1234; rq_cnt[1] = 1; alog.delete();
    run(60, "rw_done");
    chk("rw_count", alog.size(), 1);
    chk("rw_next_owner", alog[0].own, 1);
    chk("rw_next_lat", alog[0].lat, 2);
    chk("rw_next_data", alog[0].data, 16'h1234);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
